// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: owns the single write port of the 32x32 register file.
// After reset it clears registers 1..31 to INIT_VALUE, then arbitrates the CPU
// writeback (high priority) and the DDU debug unit onto the port. All write
// controls are registered: one write per cycle, fixed one-cycle latency.
// Optional feature macro: DBG_STARVE_GUARD_EN (forces a debug grant after
// STARVE_LIMIT consecutive lost cycles).
module regfile_write_arbiter #(
   parameter logic [31:0] INIT_VALUE   = 32'h0000_0000,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_cpu_wr_valid,
   output logic        o_cpu_wr_ready,
   input  logic [4:0]  i_cpu_wr_addr,
   input  logic [31:0] i_cpu_wr_data,
   input  logic        i_dbg_wr_valid,
   output logic        o_dbg_wr_ready,
   input  logic [4:0]  i_dbg_wr_addr,
   input  logic [31:0] i_dbg_wr_data,
   output logic        o_rf_we,
   output logic [4:0]  o_rf_waddr,
   output logic [31:0] o_rf_wdata,
   output logic        o_init_done
);

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // The limit must fit the 4-bit starve counter and be reachable.
   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
      $error("STARVE_LIMIT out of range 1..15");
   end

   logic [0:0]  r_state;
   logic [5:0]  r_cnt;      // sweep address; bit 5 set means sweep finished
   logic        w_run;
   logic        w_force;
   logic        w_cpu_rdy;
   logic        w_dbg_rdy;
   logic        w_cpu_xfer;
   logic        w_dbg_xfer;
   logic [4:0]  w_addr;
   logic [31:0] w_data;

   assign w_run = (r_state == ST_RUN);

`ifdef DBG_STARVE_GUARD_EN
   localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);
   logic [3:0] r_starve;

   assign w_force = w_run && (r_starve == LP_LIMIT);

   // Count consecutive cycles the debug requester waits while the CPU wins.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n)
         r_starve <= 4'd0;
      else if (w_run) begin
         if (w_dbg_xfer || !i_dbg_wr_valid)
            r_starve <= 4'd0;
         else if (w_cpu_xfer)
            r_starve <= r_starve + 4'd1;
      end
   end
`else
   assign w_force = 1'b0;
`endif

   // Readies are purely combinational; CPU wins unless debug is being forced.
   assign w_cpu_rdy  = w_run && !w_force;
   assign w_dbg_rdy  = w_run && (!i_cpu_wr_valid || w_force);
   assign w_cpu_xfer = i_cpu_wr_valid && w_cpu_rdy;
   assign w_dbg_xfer = i_dbg_wr_valid && w_dbg_rdy;
   assign w_addr     = w_cpu_xfer ? i_cpu_wr_addr : i_dbg_wr_addr;
   assign w_data     = w_cpu_xfer ? i_cpu_wr_data : i_dbg_wr_data;

   assign o_cpu_wr_ready = w_cpu_rdy;
   assign o_dbg_wr_ready = w_dbg_rdy;

   // Clear sweep, then register the winning request onto the write port.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= ST_INIT;
         r_cnt       <= 6'd1;
         o_rf_we     <= 1'b0;
         o_rf_waddr  <= 5'd0;
         o_rf_wdata  <= 32'd0;
         o_init_done <= 1'b0;
      end else begin
         case (r_state)
            ST_INIT: begin
               if (r_cnt[5]) begin
                  r_state     <= ST_RUN;
                  o_rf_we     <= 1'b0;
                  o_init_done <= 1'b1;
               end else begin
                  o_rf_we    <= 1'b1;
                  o_rf_waddr <= r_cnt[4:0];
                  o_rf_wdata <= INIT_VALUE;
                  r_cnt      <= r_cnt + 6'd1;
               end
            end
            default: begin
               if (w_cpu_xfer || w_dbg_xfer) begin
                  // Register 0 is hardwired: handshake completes, no write.
                  o_rf_we    <= |w_addr;
                  o_rf_waddr <= w_addr;
                  o_rf_wdata <= w_data;
               end else begin
                  o_rf_we <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: vector table, hand sequences for the sweep,
// starvation and mid-stream reset, and random traffic against a reference model.
module tb_regfile_write_arbiter;

   localparam logic [31:0] INIT = 32'h1234_5678;
   localparam int          LIM  = 4;
`ifdef DBG_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cv, dv;
   logic [4:0]  ca, da;
   logic [31:0] cd, dd;
   logic        c_rdy, d_rdy, we, done;
   logic [4:0]  waddr;
   logic [31:0] wdata;

   int n_vec = 0;
   int n_err = 0;

   regfile_write_arbiter #(.INIT_VALUE(INIT), .STARVE_LIMIT(LIM)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_cpu_wr_valid(cv), .o_cpu_wr_ready(c_rdy), .i_cpu_wr_addr(ca), .i_cpu_wr_data(cd),
      .i_dbg_wr_valid(dv), .o_dbg_wr_ready(d_rdy), .i_dbg_wr_addr(da), .i_dbg_wr_data(dd),
      .o_rf_we(we), .o_rf_waddr(waddr), .o_rf_wdata(wdata), .o_init_done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        cv; logic [4:0] ca; logic [31:0] cd;
      logic        dv; logic [4:0] da; logic [31:0] dd;
      logic        ecr, edr, ewe; logic [4:0] ea; logic [31:0] ed;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic drive(input logic c_v, input logic [4:0] c_a, input logic [31:0] c_d,
                        input logic d_v, input logic [4:0] d_a, input logic [31:0] d_d);
      cv = c_v; ca = c_a; cd = c_d; dv = d_v; da = d_a; dd = d_d;
      #1;
   endtask

   // 31 sweep writes then init_done on the 32nd edge; readies low throughout.
   task automatic check_sweep(input string tag);
      for (int k = 1; k <= 31; k++) begin
         chk({tag, " sweep cpu_rdy"}, 32'(c_rdy), 32'd0);
         chk({tag, " sweep dbg_rdy"}, 32'(d_rdy), 32'd0);
         tick();
         chk({tag, " sweep we"}, 32'(we), 32'd1);
         chk({tag, " sweep addr"}, 32'(waddr), 32'(k));
         chk({tag, " sweep data"}, wdata, INIT);
         chk({tag, " sweep done"}, 32'(done), 32'd0);
      end
      tick();
      chk({tag, " sweep end we"}, 32'(we), 32'd0);
      chk({tag, " sweep end done"}, 32'(done), 32'd1);
   endtask

   vec_t tbl[10];

   initial begin
      logic        m_cr, m_dr, m_cx, m_dx, m_frc;
      logic        m_we;
      logic [4:0]  m_addr;
      logic [31:0] m_data;
      int          m_starve;
      logic        hold_c, hold_d;

      tbl[0] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0,         1'b1, 1'b0, 1'b1, 5'd5,  32'hDEAD_BEEF};
      tbl[1] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0, 32'h0,         1'b1, 1'b1, 1'b0, 5'd5,  32'hDEAD_BEEF};
      tbl[2] = '{1'b1, 5'd3,  32'h1111_1111, 1'b1, 5'd7, 32'h2222_2222, 1'b1, 1'b0, 1'b1, 5'd3,  32'h1111_1111};
      tbl[3] = '{1'b0, 5'd3,  32'h1111_1111, 1'b1, 5'd7, 32'h2222_2222, 1'b1, 1'b1, 1'b1, 5'd7,  32'h2222_2222};
      tbl[4] = '{1'b1, 5'd0,  32'h3333_3333, 1'b0, 5'd0, 32'h0,         1'b1, 1'b0, 1'b0, 5'd0,  32'h3333_3333};
      tbl[5] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0, 32'h4444_4444, 1'b1, 1'b1, 1'b0, 5'd0,  32'h4444_4444};
      tbl[6] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0, 32'h0,         1'b1, 1'b1, 1'b0, 5'd0,  32'h4444_4444};
      tbl[7] = '{1'b1, 5'd31, 32'hA5A5_A5A5, 1'b0, 5'd0, 32'h0,         1'b1, 1'b0, 1'b1, 5'd31, 32'hA5A5_A5A5};
      tbl[8] = '{1'b1, 5'd1,  32'h5A5A_5A5A, 1'b0, 5'd0, 32'h0,         1'b1, 1'b0, 1'b1, 5'd1,  32'h5A5A_5A5A};
      tbl[9] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd2, 32'h0F0F_0F0F, 1'b1, 1'b1, 1'b1, 5'd2,  32'h0F0F_0F0F};

      // Reset state
      rst_n = 1'b0;
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      repeat (2) tick();
      chk("reset we", 32'(we), 32'd0);
      chk("reset addr", 32'(waddr), 32'd0);
      chk("reset data", wdata, 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset cpu_rdy", 32'(c_rdy), 32'd0);
      rst_n = 1'b1;
      check_sweep("first");

      // Directed vector table
      foreach (tbl[i]) begin
         drive(tbl[i].cv, tbl[i].ca, tbl[i].cd, tbl[i].dv, tbl[i].da, tbl[i].dd);
         chk($sformatf("vec%0d cpu_rdy", i), 32'(c_rdy), 32'(tbl[i].ecr));
         chk($sformatf("vec%0d dbg_rdy", i), 32'(d_rdy), 32'(tbl[i].edr));
         tick();
         chk($sformatf("vec%0d we", i), 32'(we), 32'(tbl[i].ewe));
         chk($sformatf("vec%0d addr", i), 32'(waddr), 32'(tbl[i].ea));
         chk($sformatf("vec%0d data", i), wdata, tbl[i].ed);
      end

      // Both requesters valid continuously
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      tick();
      for (int i = 0; i < 15; i++) begin
         bit dbg_turn;
         dbg_turn = GUARD && ((i % (LIM + 1)) == LIM);
         drive(1'b1, 5'd10, 32'hC000_0000 + 32'(i), 1'b1, 5'd20, 32'hD000_0000 + 32'(i));
         chk($sformatf("starve%0d cpu_rdy", i), 32'(c_rdy), 32'(!dbg_turn));
         chk($sformatf("starve%0d dbg_rdy", i), 32'(d_rdy), 32'(dbg_turn));
         tick();
         chk($sformatf("starve%0d addr", i), 32'(waddr), dbg_turn ? 32'd20 : 32'd10);
         chk($sformatf("starve%0d data", i), wdata,
             dbg_turn ? 32'hD000_0000 + 32'(i) : 32'hC000_0000 + 32'(i));
      end
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      tick();

      // Random traffic against the reference model
      m_starve = 0; m_addr = waddr; m_data = wdata;
      hold_c = 1'b0; hold_d = 1'b0;
      for (int i = 0; i < 300; i++) begin
         logic n_cv, n_dv;
         logic [4:0] n_ca, n_da;
         logic [31:0] n_cd, n_dd;
         n_ca = ca; n_cd = cd; n_da = da; n_dd = dd;
         // A waiting requester keeps its payload; it may still withdraw.
         if (hold_c) n_cv = ($urandom_range(0, 9) != 0);
         else begin
            n_cv = ($urandom_range(0, 2) != 0);
            n_ca = 5'($urandom); n_cd = $urandom;
         end
         if (hold_d) n_dv = ($urandom_range(0, 9) != 0);
         else begin
            n_dv = ($urandom_range(0, 1) != 0);
            n_da = 5'($urandom); n_dd = $urandom;
         end
         drive(n_cv, n_ca, n_cd, n_dv, n_da, n_dd);
         m_frc = GUARD && (m_starve == LIM);
         m_cr  = !m_frc;
         m_dr  = !n_cv || m_frc;
         m_cx  = n_cv && m_cr;
         m_dx  = n_dv && m_dr;
         m_we  = 1'b0;
         if (m_cx) begin m_we = (n_ca != 0); m_addr = n_ca; m_data = n_cd; end
         else if (m_dx) begin m_we = (n_da != 0); m_addr = n_da; m_data = n_dd; end
         if (m_dx || !n_dv) m_starve = 0;
         else if (m_cx) m_starve++;
         chk("rand cpu_rdy", 32'(c_rdy), 32'(m_cr));
         chk("rand dbg_rdy", 32'(d_rdy), 32'(m_dr));
         tick();
         chk("rand we", 32'(we), 32'(m_we));
         chk("rand addr", 32'(waddr), 32'(m_addr));
         chk("rand data", wdata, m_data);
         hold_c = n_cv && !m_cx;
         hold_d = n_dv && !m_dx;
      end

      // Reset in the middle of a CPU burst
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 5'(12 + i), 32'hB000_0000 + 32'(i), 1'b0, 5'd0, 32'h0);
         tick();
         chk("burst we", 32'(we), 32'd1);
         chk("burst addr", 32'(waddr), 32'(12 + i));
      end
      rst_n = 1'b0;
      drive(1'b1, 5'd15, 32'hB000_0003, 1'b0, 5'd0, 32'h0);
      tick();
      chk("midrst we", 32'(we), 32'd0);
      chk("midrst done", 32'(done), 32'd0);
      chk("midrst cpu_rdy", 32'(c_rdy), 32'd0);
      chk("midrst dbg_rdy", 32'(d_rdy), 32'd0);
      rst_n = 1'b1;
      #1;
      check_sweep("second");
      drive(1'b1, 5'd9, 32'h9999_0009, 1'b0, 5'd0, 32'h0);
      chk("post cpu_rdy", 32'(c_rdy), 32'd1);
      tick();
      chk("post we", 32'(we), 32'd1);
      chk("post addr", 32'(waddr), 32'd9);
      chk("post data", wdata, 32'h9999_0009);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single write port of the 32x32 register file.
- After reset, clears the file by sweeping registers 1..31 to INIT_VALUE.
- Then arbitrates two write requesters onto the port with valid/ready handshakes: CPU writeback (higher priority) and the DDU debug unit.
- All register-file write controls are registered, giving one write per cycle with fixed one-cycle latency.

Parameters:
- INIT_VALUE, 32'h0000_0000, value written to registers 1..31 during the post-reset sweep.
- STARVE_LIMIT, 4, consecutive lost cycles before the debug requester is forced through (used only with the optional feature); legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  synchronous active-low reset.
- cpu_wr_valid  in  1  CPU writeback request.
- cpu_wr_ready  out  1  CPU request accepted this cycle.
- cpu_wr_addr  in  5  CPU destination register.
- cpu_wr_data  in  32  CPU write data.
- dbg_wr_valid  in  1  DDU write request.
- dbg_wr_ready  out  1  DDU request accepted this cycle.
- dbg_wr_addr  in  5  DDU destination register.
- dbg_wr_data  in  32  DDU write data.
- rf_we  out  1  register-file write enable (RegWrite).
- rf_waddr  out  5  register-file write address (Wreg).
- rf_wdata  out  32  register-file write data (Wdata).
- init_done  out  1  high once the clear sweep has completed.

Behaviour:
- Reset: a clk edge with rst_n=0 sets state=INIT, sweep counter=1, rf_we=0, rf_waddr=0, rf_wdata=0, init_done=0, starve counter=0. This applies mid-operation too; any in-flight write is dropped.
- INIT state:
  - Each edge with rst_n=1 registers rf_we=1, rf_waddr=counter, rf_wdata=INIT_VALUE, then increments the counter.
  - Addresses 1..31 are written on 31 consecutive edges.
  - The 32nd edge moves to RUN with rf_we=0 and init_done=1.
  - cpu_wr_ready=dbg_wr_ready=0 throughout INIT.
- RUN state, readies (combinational from state, valids and starve counter):
  - cpu_wr_ready = 1 unless the debug requester is being forced.
  - dbg_wr_ready = !cpu_wr_valid, or forced.
  - At most one ready is high while both valids are high.
- Transfer occurs on the edge where valid&ready. That edge registers rf_waddr/rf_wdata from the winner and sets rf_we=1 if the address is nonzero. The write lands in the register file on the following edge, so latency from accept to the register file holding the data is 2 edges.
- Address 0:
  - The handshake completes normally.
  - rf_we stays 0, rf_waddr=0 and rf_wdata=the requester's data.
  - The register file never sees a write to register 0.
- No transfer on an edge: rf_we=0; rf_waddr/rf_wdata hold their previous values.
- Requesters hold addr/data stable while valid and not ready. Dropping valid before ready is permitted; nothing is recorded.
- Back-to-back: one accepted write per cycle sustained indefinitely, with no bubble between consecutive transfers.
- init_done stays 1 until the next reset.

Optional Feature:
- Macro: DBG_STARVE_GUARD_EN.
- Enabled:
  - A 4-bit starve counter increments on each RUN edge where dbg_wr_valid=1 and the CPU wins; it clears on a debug transfer or when dbg_wr_valid=0.
  - When counter==STARVE_LIMIT, the debug requester is forced for one cycle: dbg_wr_ready=1 and cpu_wr_ready=0.
  - The counter clears on that transfer.
- Disabled: strict CPU priority, no counter logic; the debug requester can starve indefinitely.

Test Plan:
- Reset release, no requests -> rf_we=1 for 31 edges with rf_waddr 1..31 and rf_wdata=INIT_VALUE; init_done=1 on edge 32; readies 0 before that.
- After init, cpu_wr_valid=1, addr=5, data=32'hDEAD_BEEF -> cpu_wr_ready=1; next cycle rf_we=1, rf_waddr=5, rf_wdata=32'hDEAD_BEEF.
- Both valid (cpu addr 3 / dbg addr 7) for one cycle, then CPU drops -> CPU write to 3 first, debug write to 7 on the next transfer; dbg_wr_ready=0 in cycle 1.
- Write to addr 0 from either requester -> handshake completes, rf_we stays 0.
- DBG_STARVE_GUARD_EN defined, STARVE_LIMIT=4, both valid continuously -> pattern of 4 CPU transfers then 1 debug transfer, repeating. Undefined -> debug is never granted.
- rst_n low mid-stream during a CPU burst -> next edge rf_we=0, init_done=0, readies 0; the sweep restarts at address 1 after release.
